// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns M-stage load/store requests into a
// req/ack memory transaction, stalling the pipeline until it completes.
// Optional misalignment trap enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemtoRegM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [3:0]  byteEnable,
    output logic [31:0] ReadDataM,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        err,
    output logic [1:0]  dbg_state
);

    // Handshake: mem_req stays high with mem_we/mem_addr/mem_wdata/mem_be held
    // stable until the memory returns a single-cycle mem_ack; mem_ack is
    // meaningful only while mem_req=1 and mem_rdata is sampled with it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        we_q, load_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic        accept;
    logic        stall_c;
    logic        req_c;
    logic        req;
    logic        misaligned;

    assign req = MemWriteM | MemtoRegM;

`ifdef DMEM_ALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        if (byteEnable == 4'b1111 && ALUResultM[1:0] != 2'b00) misaligned = 1'b1;
        if ((byteEnable == 4'b0011 || byteEnable == 4'b1100) && ALUResultM[0]) misaligned = 1'b1;
    end
`else
    logic [1:0] unused_addr_lo;
    assign unused_addr_lo = ALUResultM[1:0];
    assign misaligned     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        accept  = 1'b0;
        stall_c = 1'b0;
        req_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    stall_c = 1'b1;
                    cnt_d   = 8'd0;
                    if (misaligned) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        if (!MemWriteM) rdata_d = 32'h0;
                    end else begin
                        accept  = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                req_c   = 1'b1;
                // An ack on the final counted cycle still wins over the timeout.
                if (mem_ack) begin
                    state_d = DONE;
                    cnt_d   = 8'd0;
                    if (load_q) rdata_d = mem_rdata;
                end else if (cnt_q == TO_LAST) begin
                    state_d = DONE;
                    cnt_d   = 8'd0;
                    err_d   = 1'b1;
                    if (load_q) rdata_d = 32'hDEADBEEF;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            load_q  <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= MemWriteM;
                load_q  <= ~MemWriteM;
                addr_q  <= {ALUResultM[31:2], 2'b00};
                wdata_q <= WriteDataM;
                be_q    <= byteEnable;
            end
        end
    end

    // Gate with reset so the IDLE-cycle combinational stall drops at once.
    assign stall     = stall_c & reset;
    assign mem_req   = req_c;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign ReadDataM = rdata_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus randomized
// loads/stores against a behavioural model with a scoreboard queue.
module tb_dmem_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWriteM = 1'b0;
    logic        MemtoRegM = 1'b0;
    logic [31:0] ALUResultM = 32'h0;
    logic [31:0] WriteDataM = 32'h0;
    logic [3:0]  byteEnable = 4'h0;
    logic [31:0] ReadDataM;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        err;
    logic [1:0]  dbg_state;

    dmem_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .byteEnable(byteEnable),
        .ReadDataM(ReadDataM), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        we;
        logic [3:0]  be;
        logic        err;
        logic [8:0]  stall_len;
        logic [8:0]  req_cycles;
    } exp_t;

    exp_t        exp_q[$];
    int          dly_q[$];
    logic [31:0] rd_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_rdata = 32'h0;
    logic        ref_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_misaligned(input logic [31:0] a, input logic [3:0] be);
`ifdef DMEM_ALIGN_CHECK_EN
        if (be == 4'b1111) return a[1:0] != 2'b00;
        if (be == 4'b0011 || be == 4'b1100) return a[0];
        return 1'b0;
`else
        return (a[0] & ~a[0]) | (be[0] & ~be[0]);
`endif
    endfunction

    // Issue one instruction; it stays on the inputs through its DONE cycle.
    task automatic do_access(input bit no_wait, input logic w, input logic l,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, input int delay, input logic [31:0] rdv);
        exp_t e;
        int   n;
        bit   seen;
        bit   done;
        if (!no_wait) begin
            @(posedge clk);
            #1;
        end
        MemWriteM  = w;
        MemtoRegM  = l;
        ALUResultM = a;
        WriteDataM = d;
        byteEnable = be;
        e.addr  = {a[31:2], 2'b00};
        e.wdata = d;
        e.we    = w;
        e.be    = be;
        if (is_misaligned(a, be)) begin
            e.stall_len  = 9'd1;
            e.req_cycles = 9'd0;
            ref_err      = 1'b1;
            if (!w) ref_rdata = 32'h0;
        end else begin
            dly_q.push_back(delay);
            rd_q.push_back(rdv);
            if (delay <= TO) begin
                e.stall_len  = 9'(1 + delay);
                e.req_cycles = 9'(delay);
                if (!w) ref_rdata = rdv;
            end else begin
                e.stall_len  = 9'(1 + TO);
                e.req_cycles = 9'(TO);
                ref_err      = 1'b1;
                if (!w) ref_rdata = 32'hDEADBEEF;
            end
        end
        e.rdata = ref_rdata;
        e.err   = ref_err;
        exp_q.push_back(e);
        n = 0;
        seen = 1'b0;
        done = 1'b0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
            if (stall) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL access_complete actual=not_done required=done addr=%h", a);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            MemWriteM  = 1'b0;
            MemtoRegM  = 1'b0;
            ALUResultM = $urandom;
            WriteDataM = $urandom;
        end
    endtask

    // Memory model: acks on the delay-th BUSY cycle, random stray acks otherwise.
    int          rsp_cnt = 0;
    int          rsp_d = 0;
    logic [31:0] rsp_rd = 32'h0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                rsp_cnt = 0;
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (rsp_cnt == 0) begin
                    if (dly_q.size() > 0) begin
                        rsp_d  = dly_q.pop_front();
                        rsp_rd = rd_q.pop_front();
                    end else begin
                        rsp_d = 1000;
                    end
                end
                rsp_cnt++;
                if (rsp_cnt == rsp_d) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rsp_rd;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                rsp_cnt   = 0;
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: checks request outputs while mem_req is high, and pops one
    // expected record at the end of every stall run.
    bit prev_stall = 1'b0;
    bit prev_req = 1'b0;
    int run = 0;
    int req_cnt = 0;
    int req_starts = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            prev_stall = 1'b0;
            prev_req   = 1'b0;
        end else begin
            if (stall) begin
                if (!prev_stall) begin
                    run = 0;
                    req_cnt = 0;
                    req_starts = 0;
                end
                run++;
            end
            if (mem_req) begin
                if (!prev_req) req_starts++;
                req_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected actual=mem_req_high required=no_request");
                end else begin
                    chk("mem_addr", mem_addr, exp_q[0].addr);
                    chk("mem_we", {31'h0, mem_we}, {31'h0, exp_q[0].we});
                    chk("mem_be", {28'h0, mem_be}, {28'h0, exp_q[0].be});
                    chk("mem_wdata", mem_wdata, exp_q[0].wdata);
                end
            end
            if (prev_stall && !stall) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected actual=stall_fell required=no_access");
                end else begin
                    e = exp_q.pop_front();
                    chk("stall_len", 32'(run), {23'h0, e.stall_len});
                    chk("req_cycles", 32'(req_cnt), {23'h0, e.req_cycles});
                    chk("req_seqs", 32'(req_starts), (e.req_cycles != 0) ? 32'd1 : 32'd0);
                    chk("ReadDataM", ReadDataM, e.rdata);
                    chk("err", {31'h0, err}, {31'h0, e.err});
                end
            end
            prev_stall = stall;
            prev_req   = mem_req;
        end
    end

    logic [3:0] be_tab [6] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b1000, 4'b0110};

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ReadDataM"}, ReadDataM, 32'h0);
        chk({tag, "_stall"}, {31'h0, stall}, 32'h0);
        chk({tag, "_mem_req"}, {31'h0, mem_req}, 32'h0);
        chk({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_mem_be"}, {28'h0, mem_be}, 32'h0);
        chk({tag, "_err"}, {31'h0, err}, 32'h0);
        chk({tag, "_state"}, {30'h0, dbg_state}, 32'h0);
    endtask

    initial begin
        exp_t e;
        int   wait_n;
        int   op;
        // Reset held with a request present: outputs must stay at zero.
        MemtoRegM  = 1'b1;
        ALUResultM = 32'h44;
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        @(posedge clk);
        #1;
        MemtoRegM = 1'b0;
        reset = 1'b1;

        // Minimum-latency load.
        do_access(0, 1'b0, 1'b1, 32'h100, 32'h0, 4'b1111, 1, 32'hCAFEF00D);
        // Store with a 3-cycle ack, back-to-back after the load.
        do_access(0, 1'b1, 1'b0, 32'h204, 32'h12345678, 4'b0011, 3, $urandom);
        // Ack on the very last allowed cycle succeeds.
        do_access(0, 1'b0, 1'b1, 32'h3C0, $urandom, 4'b1111, TO, $urandom);
        // Both strobes high: treated as a store.
        do_access(0, 1'b1, 1'b1, 32'h50, 32'hA5A5A5A5, 4'b1111, 2, $urandom);
        // Back-to-back loads.
        do_access(0, 1'b0, 1'b1, 32'h60, $urandom, 4'b1111, 1, $urandom);
        do_access(0, 1'b0, 1'b1, 32'h64, $urandom, 4'b1111, 2, $urandom);
        idle(2);
        // Misaligned word load (trapped only when the check is built in).
        do_access(0, 1'b0, 1'b1, 32'h102, $urandom, 4'b1111, 1, $urandom);
        idle(1);
        // Timeout on a load, then a successful access keeps err set.
        do_access(0, 1'b0, 1'b1, 32'h200, $urandom, 4'b1111, TO + 5, $urandom);
        do_access(0, 1'b0, 1'b1, 32'h208, $urandom, 4'b1111, 1, $urandom);
        idle(2);

        // Reset in the middle of a BUSY access.
        @(posedge clk);
        #1;
        MemWriteM  = 1'b0;
        MemtoRegM  = 1'b1;
        ALUResultM = 32'h40;
        WriteDataM = 32'h77;
        byteEnable = 4'b1111;
        dly_q.push_back(1000);
        rd_q.push_back(32'h0);
        e = '0;
        e.addr = 32'h40;
        e.wdata = 32'h77;
        e.be = 4'b1111;
        exp_q.push_back(e);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        exp_q.delete();
        dly_q.delete();
        rd_q.delete();
        ref_rdata = 32'h0;
        ref_err   = 1'b0;
        MemtoRegM = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        // Request present at the first edge after release must be taken.
        do_access(1, 1'b0, 1'b1, 32'h8, $urandom, 4'b1111, 2, $urandom);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 5);
            wait_n = $urandom_range(0, 9);
            if (wait_n == 0) wait_n = TO + $urandom_range(1, 3);
            else if (wait_n == 1) wait_n = TO;
            else wait_n = $urandom_range(1, 4);
            do_access(0, (op >= 3) ? 1'b1 : 1'b0, (op < 3 || op == 5) ? 1'b1 : 1'b0,
                      $urandom, $urandom, be_tab[$urandom_range(0, 5)], wait_n, $urandom);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(3);

        wait_n = 0;
        while (exp_q.size() != 0 && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
